kc87_tape_capture: RTL and testbench
====================================

Name: kc87_tape_capture

Overview:
- Tape-save path for the KC87 core: the opposite direction to the TAP load path.
- Watches the emulated CPU's cassette output line and decodes the period-modulated tape signal into bytes.
- Stores the bytes in an on-chip buffer and serves them to the HPS through the hps_io upload interface (core responds to ioctl reads), so the OSD can save a TAP image.
- Sits inside the kc87 module, next to the tape-load logic.

Parameters:
- ADDR_W, 14: buffer address width; capacity 2^ADDR_W bytes.
- T_MIN, 10000: periods shorter than this (clk cycles) are noise.
- T_01, 30000: boundary between a "0" period and a "1" period.
- T_1S, 52000: boundary between a "1" period and a separator period.
- TIMEOUT, 100000: no-edge interval that ends a block; period counter saturates here.
- Defaults are sized for a 50 MHz clk: "0" = 400 us, "1" = 800 us, separator = 1.3 ms.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tape_out  in  1  CPU cassette output level (may be asynchronous)
- enable  in  1  capture armed while high
- ioctl_upload  in  1  HPS upload in progress
- ioctl_rd  in  1  HPS read strobe (one cycle)
- ioctl_addr  in  25  HPS read byte address
- ioctl_din  out  8  read data to HPS
- byte_count  out  ADDR_W+1  bytes captured
- capturing  out  1  high while the FSM is in DATA
- overflow  out  1  sticky: buffer full and a byte was dropped
- frame_err  out  1  sticky: partial byte discarded

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Reset values: ioctl_din=0, byte_count=0, capturing=0, overflow=0, frame_err=0, FSM=IDLE, period counter=TIMEOUT (saturated).
- Buffer RAM contents are not cleared by reset.
- Input conditioning: tape_out passes through a 2-FF synchronizer. A rising edge is detected on the synchronized signal; this adds 3 cycles of fixed latency.
- Period counter:
  - 17-bit, increments each clk, saturates at TIMEOUT.
  - Cleared to 0 on every rising edge.
  - The value at the edge, captured before the clear, is the measured period p.
  - An edge that arrives while the counter is saturated gives no classification; it only restarts measurement.
- Classification of p:
  - p<T_MIN: NOISE
  - T_MIN<=p<T_01: ZERO
  - T_01<=p<T_1S: ONE
  - T_1S<=p<TIMEOUT: SEP
- FSM states IDLE, WAIT_SEP, DATA:
  - IDLE: entered whenever enable=0. On enable 0->1: byte_count, overflow and frame_err clear to 0 on that cycle, then go to WAIT_SEP.
  - WAIT_SEP: ZERO, ONE and NOISE are ignored (leader). SEP -> DATA with bit count 0.
  - DATA:
    - ZERO/ONE shift in as data bits, LSB first.
    - On the 8th bit the byte is written to RAM at address byte_count on the next cycle, byte_count increments on that same cycle, and the FSM stays in DATA with bit count 0.
    - SEP with bit count 0 is the normal inter-byte separator: no action.
    - SEP with bit count 1..7 discards the partial byte, sets frame_err, and stays in DATA with bit count 0.
    - NOISE discards any partial byte (sets frame_err if bit count >0) and goes to WAIT_SEP.
    - Counter reaching TIMEOUT: a partial byte is discarded the same way, then go to WAIT_SEP (end of block).
  - enable falling in any state -> IDLE immediately; a partial byte is dropped, and frame_err is not set.
- Full buffer: when byte_count = 2^ADDR_W, further completed bytes are not written, byte_count holds, and overflow is set (sticky until the next enable rise or reset).
- Upload port:
  - Dual-port RAM: capture writes on port A, HPS reads on port B; no arbitration is needed.
  - On ioctl_rd=1, ioctl_addr is sampled. On the next cycle ioctl_din = RAM[ioctl_addr[ADDR_W-1:0]] if ioctl_addr < byte_count, else 0x00.
  - ioctl_din holds until the next ioctl_rd.
  - ioctl_rd is honoured regardless of ioctl_upload. ioctl_upload only gates nothing internally and is reserved for status.
- Simultaneous read and write to the same address: the read returns the old data, or 0x00 if the address is not yet below byte_count at sample time.
- capturing = (state==DATA).

Test Plan:
- Reset mid-DATA with 3 bits shifted: assert reset -> all outputs return to reset values within the same cycle (asynchronous); a following ZERO pattern with no SEP captures nothing.
- enable=1; 20 ZERO leader periods, SEP, then bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), SEP, bits of 0x3C -> byte_count=2; upload reads at addr 0 and 1 return 0xA5 and 0x3C one cycle after ioctl_rd; read at addr 2 returns 0x00.
- Inside a frame: 5 bits then SEP -> frame_err=1, byte_count unchanged; next 8 bits form a valid byte at the next address.
- Edge spacing 2000 cycles (NOISE) mid-byte -> frame_err=1, state WAIT_SEP, capturing=0; bits before the next SEP are ignored.
- ADDR_W=4: capture 17 bytes -> byte_count=16, overflow=1, RAM[15] holds the 16th byte; enable 0->1 clears byte_count, overflow and frame_err.
- Block end: stop tape_out toggling for more than TIMEOUT cycles -> capturing falls exactly TIMEOUT cycles after the last edge; the first edge afterwards produces no bit.

Source files
------------

// File: rtl/kc87_tape_capture.sv
// kc87_tape_capture
//   Decodes the KC87 cassette output (period-modulated rising edges) into
//   bytes, stores them in an on-chip buffer and serves them to the HPS via
//   the ioctl upload (read) interface so the OSD can save a TAP image.
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   tape_out_i     CPU cassette output level (asynchronous to clk_i)
//   enable_i       capture armed while high; a rising edge restarts the buffer
//   ioctl_upload_i HPS upload in progress (status only)
//   ioctl_rd_i     HPS read strobe, one cycle
//   ioctl_addr_i   HPS read byte address
//   ioctl_din_o    read data, valid the cycle after ioctl_rd_i, held
//   byte_count_o   number of bytes captured
//   capturing_o    high while decoding data bytes
//   overflow_o     sticky: a completed byte was dropped because buffer is full
//   frame_err_o    sticky: a partial byte was discarded
module kc87_tape_capture #(
  parameter int ADDR_W  = 14,
  parameter int T_MIN   = 10000,
  parameter int T_01    = 30000,
  parameter int T_1S    = 52000,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tape_out_i,
  input  logic              enable_i,
  input  logic              ioctl_upload_i,
  input  logic              ioctl_rd_i,
  input  logic [24:0]       ioctl_addr_i,
  output logic [7:0]        ioctl_din_o,
  output logic [ADDR_W:0]   byte_count_o,
  output logic              capturing_o,
  output logic              overflow_o,
  output logic              frame_err_o
);

  localparam logic [16:0]     T_MIN_C = 17'(T_MIN);
  localparam logic [16:0]     T_01_C  = 17'(T_01);
  localparam logic [16:0]     T_1S_C  = 17'(T_1S);
  localparam logic [16:0]     TMO_C   = 17'(TIMEOUT);
  localparam logic [ADDR_W:0] CAP_C   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SEP = 2'd1,
    S_DATA     = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    C_NONE  = 3'd0,
    C_NOISE = 3'd1,
    C_ZERO  = 3'd2,
    C_ONE   = 3'd3,
    C_SEP   = 3'd4
  } cls_t;

  logic              tape_s1_q, tape_s2_q, tape_s3_q;
  logic              en_q;
  logic [16:0]       cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              wr_pend_q, wr_pend_d;
  logic [7:0]        wr_byte_q, wr_byte_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic [7:0]        din_q;
  logic [7:0]        mem_q [0:(1<<ADDR_W)-1];

  logic              rise_s, tmo_s, bit_s, wr_en_s, rd_en_s, addr_hit_s;
  cls_t              cls_s;

  assign rise_s = tape_s2_q & ~tape_s3_q;
  // Fires on the cycle the counter steps into saturation (end of block).
  assign tmo_s  = ~rise_s & (cnt_q == (TMO_C - 17'd1));
  assign bit_s  = (cls_s == C_ONE);
  // Reads are served whether or not an upload is flagged; the flag is status only.
  assign rd_en_s    = ioctl_rd_i & (ioctl_upload_i | 1'b1);
  assign addr_hit_s = ioctl_addr_i < {{(24 - ADDR_W){1'b0}}, byte_count_q};

  // Classify the period that ends at this rising edge.
  always_comb begin
    cls_s = C_NONE;
    if (rise_s && (cnt_q != TMO_C)) begin
      if (cnt_q < T_MIN_C) begin
        cls_s = C_NOISE;
      end else if (cnt_q < T_01_C) begin
        cls_s = C_ZERO;
      end else if (cnt_q < T_1S_C) begin
        cls_s = C_ONE;
      end else begin
        cls_s = C_SEP;
      end
    end else begin
      cls_s = C_NONE;
    end
  end

  // Period counter: cleared on each edge, saturates at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (rise_s) begin
      cnt_d = 17'd0;
    end else if (cnt_q != TMO_C) begin
      cnt_d = cnt_q + 17'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Capture FSM next-state and buffer bookkeeping.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    wr_pend_d    = 1'b0;
    wr_byte_d    = wr_byte_q;
    byte_count_d = byte_count_q;
    overflow_d   = overflow_q;
    frame_err_d  = frame_err_q;
    wr_en_s      = 1'b0;

    // A byte completed last cycle is committed now, or dropped when full.
    if (wr_pend_q) begin
      if (byte_count_q < CAP_C) begin
        wr_en_s      = 1'b1;
        byte_count_d = byte_count_q + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end

    if (!enable_i) begin
      state_d  = S_IDLE;
      bitcnt_d = 3'd0;
    end else if (!en_q) begin
      byte_count_d = '0;
      overflow_d   = 1'b0;
      frame_err_d  = 1'b0;
      bitcnt_d     = 3'd0;
      state_d      = S_WAIT_SEP;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_WAIT_SEP: begin
          if (cls_s == C_SEP) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end else begin
            state_d = S_WAIT_SEP;
          end
        end
        S_DATA: begin
          case (cls_s)
            C_ZERO, C_ONE: begin
              shift_d = {bit_s, shift_q[7:1]};
              if (bitcnt_q == 3'd7) begin
                wr_pend_d = 1'b1;
                wr_byte_d = {bit_s, shift_q[7:1]};
                bitcnt_d  = 3'd0;
              end else begin
                bitcnt_d = bitcnt_q + 3'd1;
              end
            end
            C_SEP: begin
              frame_err_d = frame_err_q | (bitcnt_q != 3'd0);
              bitcnt_d    = 3'd0;
            end
            C_NOISE: begin
              frame_err_d = frame_err_q | (bitcnt_q != 3'd0);
              bitcnt_d    = 3'd0;
              state_d     = S_WAIT_SEP;
            end
            default: begin
              if (tmo_s) begin
                frame_err_d = frame_err_q | (bitcnt_q != 3'd0);
                bitcnt_d    = 3'd0;
                state_d     = S_WAIT_SEP;
              end else begin
                state_d = S_DATA;
              end
            end
          endcase
        end
        default: begin
          state_d  = S_IDLE;
          bitcnt_d = 3'd0;
        end
      endcase
    end
  end

  // State, synchronizer, counter, status and read-data registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tape_s1_q    <= 1'b0;
      tape_s2_q    <= 1'b0;
      tape_s3_q    <= 1'b0;
      en_q         <= 1'b0;
      cnt_q        <= TMO_C;
      state_q      <= S_IDLE;
      bitcnt_q     <= 3'd0;
      shift_q      <= 8'h00;
      wr_pend_q    <= 1'b0;
      wr_byte_q    <= 8'h00;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      din_q        <= 8'h00;
    end else begin
      tape_s1_q    <= tape_out_i;
      tape_s2_q    <= tape_s1_q;
      tape_s3_q    <= tape_s2_q;
      en_q         <= enable_i;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      wr_pend_q    <= wr_pend_d;
      wr_byte_q    <= wr_byte_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      // Addresses at or beyond the captured length read as zero.
      if (rd_en_s) begin
        din_q <= addr_hit_s ? mem_q[ioctl_addr_i[ADDR_W-1:0]] : 8'h00;
      end else begin
        din_q <= din_q;
      end
    end
  end

  // Capture buffer write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[byte_count_q[ADDR_W-1:0]] <= wr_byte_q;
    end
  end

  assign ioctl_din_o  = din_q;
  assign byte_count_o = byte_count_q;
  assign capturing_o  = (state_q == S_DATA);
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_kc87_tape_capture.sv
// Directed bench for kc87_tape_capture with scaled-down timing parameters.
module tb_kc87_tape_capture;

  localparam int ADDR_W = 4;
  localparam int TMO    = 100;
  localparam int ZP     = 20;   // "0" edge spacing
  localparam int OP     = 40;   // "1" edge spacing
  localparam int SP     = 70;   // separator edge spacing
  localparam int NP     = 5;    // noise edge spacing

  logic              clk = 1'b0;
  logic              rst;
  logic              tape_out;
  logic              enable;
  logic              ioctl_upload;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic [ADDR_W:0]   byte_count;
  logic              capturing;
  logic              overflow;
  logic              frame_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int          phase;
    logic [24:0] addr;
    logic [7:0]  exp;
  } rd_vec_t;

  rd_vec_t tbl [12];

  kc87_tape_capture #(
    .ADDR_W(ADDR_W), .T_MIN(10), .T_01(30), .T_1S(52), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tape_out_i(tape_out), .enable_i(enable),
    .ioctl_upload_i(ioctl_upload), .ioctl_rd_i(ioctl_rd), .ioctl_addr_i(ioctl_addr),
    .ioctl_din_o(ioctl_din), .byte_count_o(byte_count), .capturing_o(capturing),
    .overflow_o(overflow), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One rising edge followed by a low phase; edges are exactly 'per' cycles apart.
  task automatic pulse(input int per);
    tape_out = 1'b1;
    repeat (per / 2) @(negedge clk);
    tape_out = 1'b0;
    repeat (per - per / 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) pulse(v[i] ? OP : ZP);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    @(negedge clk);
    ioctl_rd = 1'b0;
    chk(name, {24'd0, ioctl_din}, {24'd0, exp});
  endtask

  task automatic run_reads(input int ph);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].phase == ph) begin
        do_read(tbl[i].addr, tbl[i].exp, $sformatf("read_p%0d_a%0h", ph, tbl[i].addr));
      end
    end
  endtask

  task automatic toggle_enable();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("idle_capturing", {31'd0, capturing}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("en_clr_count", {27'd0, byte_count}, 32'd0);
    chk("en_clr_ovf", {31'd0, overflow}, 32'd0);
    chk("en_clr_ferr", {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 25'h0,       8'hA5};
    tbl[1]  = '{1, 25'h1,       8'h3C};
    tbl[2]  = '{1, 25'h2,       8'h5A};
    tbl[3]  = '{1, 25'h3,       8'h00};
    tbl[4]  = '{1, 25'h1000000, 8'h00};
    tbl[5]  = '{2, 25'h0,       8'h10};
    tbl[6]  = '{2, 25'h7,       8'h17};
    tbl[7]  = '{2, 25'hF,       8'h1F};
    tbl[8]  = '{2, 25'h10,      8'h00};
    tbl[9]  = '{3, 25'h1,       8'h00};
    tbl[10] = '{3, 25'h0,       8'h77};
    tbl[11] = '{0, 25'h0,       8'h00};

    rst = 1'b1; tape_out = 1'b0; enable = 1'b0;
    ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_din", {24'd0, ioctl_din}, 32'd0);
    chk("rst_count", {27'd0, byte_count}, 32'd0);
    chk("rst_capturing", {31'd0, capturing}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Leader, separator, 0xA5, separator, 0x3C, separator.
    repeat (20) pulse(ZP);
    chk("leader_not_capturing", {31'd0, capturing}, 32'd0);
    pulse(SP);
    send_byte(8'hA5);
    pulse(SP);
    send_byte(8'h3C);
    pulse(SP);
    chk("main_count", {27'd0, byte_count}, 32'd2);
    chk("main_capturing", {31'd0, capturing}, 32'd1);
    do_read(25'h2, 8'h00, "main_read_a2");

    // Five bits then a separator: partial byte dropped, next byte lands at addr 2.
    pulse(OP); pulse(OP); pulse(ZP); pulse(OP); pulse(ZP);
    pulse(SP);
    send_byte(8'h5A);
    pulse(SP);
    chk("frame_ferr", {31'd0, frame_err}, 32'd1);
    chk("frame_count", {27'd0, byte_count}, 32'd3);
    run_reads(1);
    toggle_enable();

    // Noise edge after three bits: back to WAIT_SEP, following bits ignored.
    repeat (TMO + 20) @(negedge clk);
    pulse(SP);
    pulse(OP); pulse(ZP); pulse(OP);
    pulse(NP);
    send_byte(8'hFF);
    chk("noise_ferr", {31'd0, frame_err}, 32'd1);
    chk("noise_capturing", {31'd0, capturing}, 32'd0);
    chk("noise_count", {27'd0, byte_count}, 32'd0);

    // Reset in the middle of a byte with three bits shifted.
    repeat (TMO + 20) @(negedge clk);
    pulse(SP);
    pulse(OP); pulse(ZP); pulse(OP); pulse(OP);
    chk("pre_rst_capturing", {31'd0, capturing}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_capturing", {31'd0, capturing}, 32'd0);
    chk("async_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("async_rst_count", {27'd0, byte_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) pulse(ZP);
    chk("post_rst_count", {27'd0, byte_count}, 32'd0);
    chk("post_rst_capturing", {31'd0, capturing}, 32'd0);

    // Seventeen bytes into a sixteen-byte buffer.
    toggle_enable();
    repeat (TMO + 20) @(negedge clk);
    pulse(SP);
    for (int i = 0; i < 17; i++) begin
      send_byte(8'h10 + 8'(i));
      pulse(SP);
    end
    chk("ovf_count", {27'd0, byte_count}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_ferr", {31'd0, frame_err}, 32'd0);
    run_reads(2);
    toggle_enable();

    // Block end: capturing falls TIMEOUT cycles after the last registered edge.
    repeat (TMO + 20) @(negedge clk);
    pulse(SP);
    send_byte(8'h77);
    @(negedge clk);
    tape_out = 1'b1;
    repeat (10) @(posedge clk);
    #1 tape_out = 1'b0;
    repeat (TMO + 2 - 10) @(posedge clk);
    #1 chk("tmo_still_capturing", {31'd0, capturing}, 32'd1);
    @(posedge clk);
    #1 chk("tmo_fall", {31'd0, capturing}, 32'd0);
    chk("tmo_count", {27'd0, byte_count}, 32'd1);
    chk("tmo_ferr", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    send_byte(8'h42);
    pulse(SP);
    chk("after_tmo_count", {27'd0, byte_count}, 32'd1);
    chk("after_tmo_capturing", {31'd0, capturing}, 32'd0);
    run_reads(3);
    repeat (5) @(negedge clk);
    chk("din_hold", {24'd0, ioctl_din}, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
